// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: single-outstanding instruction fetch controller.
// Reads the current PC, fetches one 32-bit instruction at a time over the
// instruction bus, and holds it in a one-entry buffer until decode takes it.
// It also drives the PC register's next value and write enable.
// Misaligned PCs never reach the bus. Instead, the buffer is loaded with a
// flagged NOP so that decode can raise the trap.
module ifetch_ctrl #(
    parameter int          XLEN     = 64,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_cur,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_we,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            ibus_req_valid,
    output logic [XLEN-1:0] ibus_req_addr,
    input  logic            ibus_req_ready,
    input  logic            ibus_resp_valid,
    input  logic [31:0]     ibus_resp_data,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_misaligned,
    input  logic            inst_ready
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t          state_q;
    logic            drop_q;
    logic            inst_valid_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic            inst_misaligned_q;

    logic            pc_misaligned;

    assign pc_misaligned = (pc_cur[1:0] != 2'b00);

    assign inst_valid      = inst_valid_q;
    assign inst            = inst_q;
    assign inst_pc         = inst_pc_q;
    assign inst_misaligned = inst_misaligned_q;

    // Bus request and PC update decode. A redirect always wins. Everything is forced low while in reset.
    always_comb begin
        ibus_req_valid = 1'b0;
        ibus_req_addr  = '0;
        pc_we          = 1'b0;
        pc_next        = '0;
        if (!rst) begin
            ibus_req_addr  = pc_cur;
            ibus_req_valid = (state_q == S_REQ) && !redirect_valid && !pc_misaligned;
            if (redirect_valid) begin
                pc_we   = 1'b1;
                pc_next = redirect_target;
            end else if ((state_q == S_WAIT) && ibus_resp_valid && !drop_q) begin
                pc_we   = 1'b1;
                pc_next = pc_cur + XLEN'(4);
            end
        end
    end

    // Fetch FSM and output buffer. A redirect taken while a request is still in flight sets drop, which squashes the stale response when it arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_REQ;
            drop_q            <= 1'b0;
            inst_valid_q      <= 1'b0;
            inst_q            <= '0;
            inst_pc_q         <= '0;
            inst_misaligned_q <= 1'b0;
        end else if (redirect_valid) begin
            inst_valid_q <= 1'b0;
            unique case (state_q)
                S_REQ:  state_q <= S_REQ;
                S_HOLD: state_q <= S_REQ;
                S_WAIT: begin
                    if (ibus_resp_valid) begin
                        state_q <= S_REQ;
                        drop_q  <= 1'b0;
                    end else begin
                        drop_q  <= 1'b1;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (pc_misaligned) begin
                        inst_q            <= NOP_INST;
                        inst_pc_q         <= pc_cur;
                        inst_misaligned_q <= 1'b1;
                        inst_valid_q      <= 1'b1;
                        state_q           <= S_HOLD;
                    end else if (ibus_req_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ibus_resp_valid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            inst_q            <= ibus_resp_data;
                            inst_pc_q         <= pc_cur;
                            inst_misaligned_q <= 1'b0;
                            inst_valid_q      <= 1'b1;
                            state_q           <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (inst_ready && inst_valid_q) begin
                        inst_valid_q <= 1'b0;
                        state_q      <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

endmodule
